// File: rtl/llc_flush_sequencer_pkg.sv
// Shared geometry constants and FSM state type for the LLC flush/reset walker.
package llc_flush_sequencer_pkg;

    localparam int LLC_SETS     = 4;
    localparam int LLC_WAYS     = 2;
    localparam int LLC_SET_BITS = $clog2(LLC_SETS);
    localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } llc_flush_state_t;

endpackage

// File: rtl/llc_flush_walk_cnt.sv
// Set-major / way-minor line counter; saturates on the last line of the cache.
module llc_flush_walk_cnt #(
    parameter int SETS = 4,
    parameter int WAYS = 2,
    localparam int SET_BITS = $clog2(SETS),
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [SET_BITS-1:0] set_idx,
    output logic [WAY_BITS-1:0] way_idx,
    output logic                last
);
    import llc_flush_sequencer_pkg::*;

    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(WAYS - 1);
    localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);
    localparam logic [WAY_BITS-1:0] WAY_ONE  = WAY_BITS'(1);

    assign last = (set_idx == SET_LAST) && (way_idx == WAY_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (clr) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (inc && !last) begin
            if (way_idx == WAY_LAST) begin
                way_idx <= '0;
                set_idx <= set_idx + SET_ONE;
            end else begin
                way_idx <= way_idx + WAY_ONE;
            end
        end
    end

endmodule

// File: rtl/llc_flush_sequencer.sv
// Walks every LLC line once per start request, bounding in-flight line operations,
// then waits for all completions before reporting done.
module llc_flush_sequencer #(
    parameter int LLC_SETS  = llc_flush_sequencer_pkg::LLC_SETS,
    parameter int LLC_WAYS  = llc_flush_sequencer_pkg::LLC_WAYS,
    parameter int MAX_OUTST = 2,
    localparam int SET_BITS = $clog2(LLC_SETS),
    localparam int WAY_BITS = $clog2(LLC_WAYS),
    localparam int OUT_BITS = $clog2(MAX_OUTST + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                pause,
    output logic                line_valid,
    input  logic                line_ready,
    output logic [SET_BITS-1:0] line_set,
    output logic [WAY_BITS-1:0] line_way,
    input  logic                line_done,
    output logic                done_valid,
    input  logic                done_ready,
    output logic                busy,
    output logic                err_underflow
);
    import llc_flush_sequencer_pkg::*;

    localparam logic [OUT_BITS-1:0] OUT_LIMIT = OUT_BITS'(MAX_OUTST);
    localparam logic [OUT_BITS-1:0] OUT_ONE   = OUT_BITS'(1);

    llc_flush_state_t    state;
    logic [OUT_BITS-1:0] outst;
    logic [OUT_BITS-1:0] outst_next;
    logic                start_acc;
    logic                line_hs;
    logic                walk_last;
    logic                underflow;

    assign start_acc   = (state == IDLE) && start_valid;
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done_valid  = (state == DONE);
    // pause only masks the offer; everything downstream of the handshake keeps running
    assign line_valid  = (state == ISSUE) && !pause && (outst < OUT_LIMIT);
    assign line_hs     = line_valid && line_ready;

    llc_flush_walk_cnt #(
        .SETS (LLC_SETS),
        .WAYS (LLC_WAYS)
    ) u_walk_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .inc     (line_hs),
        .set_idx (line_set),
        .way_idx (line_way),
        .last    (walk_last)
    );

    always_comb begin
        outst_next = outst;
        underflow  = 1'b0;
        if (line_hs && !line_done) begin
            outst_next = outst + OUT_ONE;
        end else if (line_done && !line_hs) begin
            if (outst == '0) begin
                underflow = 1'b1;
            end else begin
                outst_next = outst - OUT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            outst         <= '0;
            err_underflow <= 1'b0;
        end else begin
            err_underflow <= err_underflow || underflow;
            outst         <= start_acc ? '0 : outst_next;
            case (state)
                IDLE:    if (start_valid) state <= ISSUE;
                ISSUE:   if (line_hs && walk_last) state <= DRAIN;
                // leave one cycle after the count settles at zero, counting this cycle's completion
                DRAIN:   if (outst_next == '0) state <= DONE;
                DONE:    if (done_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_flush_sequencer.sv
// Scoreboard bench: expected line order pushed per accepted start, monitor pops on handshakes.
module tb_llc_flush_sequencer;
    import llc_flush_sequencer_pkg::*;

    localparam int SETS = LLC_SETS;
    localparam int WAYS = LLC_WAYS;
    localparam int MAXO = 2;
    localparam int LINES = SETS * WAYS;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start_valid;
    logic                    start_ready;
    logic                    pause;
    logic                    line_valid;
    logic                    line_ready;
    logic [LLC_SET_BITS-1:0] line_set;
    logic [LLC_WAY_BITS-1:0] line_way;
    logic                    line_done;
    logic                    done_valid;
    logic                    done_ready;
    logic                    busy;
    logic                    err_underflow;

    always #5 clk = ~clk;

    llc_flush_sequencer #(
        .LLC_SETS  (SETS),
        .LLC_WAYS  (WAYS),
        .MAX_OUTST (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .pause         (pause),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .line_set      (line_set),
        .line_way      (line_way),
        .line_done     (line_done),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { int s; int w; } line_t;
    line_t exp_q[$];
    int    done_q[$];

    // reference model of the sequencer's externally visible behaviour
    bit m_idle  = 1'b1;
    bit m_issue = 1'b0;
    bit m_drain = 1'b0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    int pend    = 0;
    int hs_count = 0;
    int walk_id = 0;
    int done_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: required event not seen within cycle budget (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_issue = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_err = 1'b0;
        pend = 0;
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_line_valid"}, line_valid, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_underflow, 0);
        check({tag, "_line_set"}, line_set, 0);
        check({tag, "_line_way"}, line_way, 0);
    endtask

    // monitor: compare against the model, then advance the model to the next edge
    always @(negedge clk) begin
        bit mv, hs, dn;
        line_t ln;
        if (rst) begin
            mv = m_issue && !pause && (pend < MAXO);
            check("mon_start_ready", start_ready, m_idle);
            check("mon_busy", busy, !m_idle);
            check("mon_done_valid", done_valid, m_done);
            check("mon_line_valid", line_valid, mv);
            check("mon_err_underflow", err_underflow, m_err);
            if (mv && exp_q.size() > 0) begin
                check("mon_line_set", line_set, exp_q[0].s);
                check("mon_line_way", line_way, exp_q[0].w);
            end
            hs = mv && line_ready;
            dn = line_done;
            if (hs && !dn) pend++;
            else if (dn && !hs) begin
                if (pend == 0) m_err = 1'b1;
                else pend--;
            end
            if (m_idle) begin
                if (start_valid) begin
                    m_idle = 1'b0;
                    m_issue = 1'b1;
                    pend = 0;
                    exp_q.delete();
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++) begin
                            ln.s = s; ln.w = w;
                            exp_q.push_back(ln);
                        end
                    walk_id++;
                    done_q.push_back(walk_id);
                end
            end else if (m_issue) begin
                if (hs) begin
                    hs_count++;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_issue = 1'b0;
                        m_drain = 1'b1;
                    end
                end
            end else if (m_drain) begin
                if (pend == 0) begin
                    m_drain = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done && done_ready) begin
                check("mon_done_token", done_q.size(), 1);
                if (done_q.size() > 0) void'(done_q.pop_front());
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    // completion responder for the automatic modes; mode 0 leaves line_done to the driver
    always @(posedge clk) begin
        #1;
        if (done_mode == 1) line_done = (pend > 0);
        else if (done_mode == 2) line_done = (pend > 0) && ($urandom_range(0, 2) == 0);
    end

    task automatic do_start();
        bit ok;
        ok = 1'b0;
        start_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (start_ready) ok = 1'b1;
            tick();
        end
        start_valid = 1'b0;
        if (!ok) note_timeout("start_accept");
    endtask

    task automatic wait_done_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) note_timeout("done_valid_wait");
    endtask

    task automatic run_walk(input bit rnd, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (rnd) begin
                line_ready = ($urandom_range(0, 3) != 0);
                pause      = ($urandom_range(0, 4) == 0);
                done_ready = $urandom_range(0, 1);
            end else begin
                done_ready = 1'b1;
            end
            if (done_valid && done_ready) ok = 1'b1;
            tick();
        end
        done_ready = 1'b0;
        pause = 1'b0;
        line_ready = 1'b1;
        if (!ok) note_timeout("walk_complete");
    endtask

    task automatic wait_line(input int s, input int w, input bit any_way, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (line_valid && line_set == s && (any_way || line_way == w)) ok = 1'b1;
            else tick();
        end
        if (!ok) note_timeout(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b0;
        start_valid = 1'b0;
        pause = 1'b0;
        line_ready = 1'b0;
        line_done = 1'b0;
        done_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("por");
        rst = 1'b1;
        tick();

        // full walk, completion one cycle after each accept
        line_ready = 1'b1;
        done_mode = 1;
        hs_count = 0;
        do_start();
        wait_done_valid(60);
        check("walk1_lines", hs_count, LINES);
        tick();
        tick();
        check("done_held", done_valid, 1);
        check("done_busy", busy, 1);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("back_idle_ready", start_ready, 1);
        check("back_idle_busy", busy, 0);

        // back-pressure on line (1,1)
        hs_count = 0;
        do_start();
        wait_line(1, 1, 1'b0, "reach_line_1_1");
        line_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", line_valid, 1);
            check("stall_set", line_set, 1);
            check("stall_way", line_way, 1);
        end
        line_ready = 1'b1;
        run_walk(1'b0, 80);
        check("stall_walk_lines", hs_count, LINES);

        // completions withheld: outstanding limit stops issue
        done_mode = 0;
        line_done = 1'b0;
        hs_count = 0;
        do_start();
        repeat (6) tick();
        check("limit_hs", hs_count, MAXO);
        check("limit_valid", line_valid, 0);
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        repeat (4) tick();
        check("limit_one_more", hs_count, MAXO + 1);
        done_mode = 1;
        run_walk(1'b0, 80);
        check("limit_walk_lines", hs_count, LINES);

        // pause mid-walk while a completion arrives
        done_mode = 0;
        line_done = 1'b0;
        hs_count = 0;
        do_start();
        repeat (3) tick();
        pause = 1'b1;
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        c = hs_count;
        repeat (4) tick();
        check("pause_no_hs", hs_count, c);
        check("pause_no_valid", line_valid, 0);
        pause = 1'b0;
        #1;
        check("resume_valid", line_valid, 1);
        check("resume_set", line_set, 1);
        check("resume_way", line_way, 0);
        done_mode = 1;
        run_walk(1'b0, 80);
        check("pause_walk_lines", hs_count, LINES);

        // underflow in IDLE is sticky across a later walk
        tick();
        check("err_clear", err_underflow, 0);
        done_mode = 0;
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        tick();
        check("err_set", err_underflow, 1);
        done_mode = 1;
        hs_count = 0;
        do_start();
        run_walk(1'b0, 80);
        check("err_sticky", err_underflow, 1);
        check("err_walk_lines", hs_count, LINES);

        // reset during set 2 abandons the walk
        hs_count = 0;
        do_start();
        wait_line(2, 0, 1'b1, "reach_set_2");
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        hs_count = 0;
        do_start();
        check("restart_valid", line_valid, 1);
        check("restart_set", line_set, 0);
        check("restart_way", line_way, 0);
        start_valid = 1'b1;
        wait_done_valid(60);
        check("restart_lines", hs_count, LINES);
        check("held_start_ready", start_ready, 0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("held_start_idle", start_ready, 1);
        hs_count = 0;
        tick();
        start_valid = 1'b0;
        check("held_start_taken", busy, 1);
        run_walk(1'b0, 80);
        check("held_walk_lines", hs_count, LINES);

        // randomized traffic
        for (int k = 0; k < 6; k++) begin
            done_mode = 2;
            hs_count = 0;
            do_start();
            run_walk(1'b1, 800);
            check("rand_walk_lines", hs_count, LINES);
        end
        done_mode = 1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/llc_flush_sequencer.md
LLC_FLUSH_SEQUENCER -- requirements
Module: llc_flush_sequencer

Interface
REQ-001 Parameter: LLC_SETS, package `LLC_SETS, number of sets walked (power of two, >=2).
REQ-002 Parameter: LLC_WAYS, package `LLC_WAYS, ways per set (power of two, >=2).
REQ-003 Parameter: MAX_OUTST, 2, maximum issued-but-uncompleted line operations (1..7).
REQ-004 Port: clk  input  1  clock; all state updates on posedge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: start_valid  input  1  flush/reset request from the testbench-reset interface.
REQ-007 Port: start_ready  output  1  request accepted this cycle.
REQ-008 Port: pause  input  1  decoder has higher-priority work; suppresses new issues only.
REQ-009 Port: line_valid  output  1  line operation offered to the datapath.
REQ-010 Port: line_ready  input  1  datapath accepts the offered line.
REQ-011 Port: line_set  output  `LLC_SET_BITS  set index of the offered line.
REQ-012 Port: line_way  output  `LLC_WAY_BITS  way index of the offered line.
REQ-013 Port: line_done  input  1  one previously accepted line has completed (pulse).
REQ-014 Port: done_valid  output  1  whole-cache walk complete.
REQ-015 Port: done_ready  input  1  consumer takes completion.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: err_underflow  output  1  sticky; line_done received with zero outstanding.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE, held in a registered state variable.
REQ-019 IDLE: start_ready=1; on start_valid SHALL clear set/way counters and outstanding, go to ISSUE next cycle.
REQ-020 start_ready SHALL be 0 in all non-IDLE states; a start_valid arriving then is held off, not dropped.
REQ-021 ISSUE: line_valid = !pause && (outstanding < MAX_OUTST); line_set/line_way driven from counters, stable while line_valid && !line_ready.
REQ-022 pause SHALL only gate line_valid; counters, outstanding, and line_done handling continue.
REQ-023 On line_valid && line_ready: way increments; at way==LLC_WAYS-1 way wraps to 0 and set increments.
REQ-024 Handshake at set==LLC_SETS-1 and way==LLC_WAYS-1 SHALL move to DRAIN; counters SHALL not wrap past the last line.
REQ-025 Outstanding: +1 on line handshake, -1 on line_done, unchanged when both occur in the same cycle; width $clog2(MAX_OUTST+1).
REQ-026 line_done with outstanding==0 and no same-cycle handshake SHALL leave outstanding at 0 and set err_underflow.
REQ-027 DRAIN: line_valid=0; move to DONE the cycle after outstanding reaches 0 (including the cycle line_done makes it 0).
REQ-028 DONE: done_valid=1 until done_ready; on done_ready return to IDLE.
REQ-029 Exactly LLC_SETS*LLC_WAYS line handshakes SHALL occur per start, in ascending set-major, way-minor order.
REQ-030 Latency: start accept -> first line_valid one cycle later when pause=0.

Reset
REQ-031 On rst low, asynchronously: state=IDLE, set=0, way=0, outstanding=0, err_underflow=0.
REQ-032 Outputs in reset: start_ready=1, line_valid=0, done_valid=0, busy=0, err_underflow=0, line_set=0, line_way=0.
REQ-033 Reset mid-walk SHALL abandon the walk silently; no done_valid is produced for it.
REQ-034 err_underflow SHALL clear only on reset.

Structure
REQ-035 `LLC_SETS, `LLC_WAYS, `LLC_SET_BITS, `LLC_WAY_BITS SHALL come from spandex_consts.svh; the state enum llc_flush_state_t SHALL be added to spandex_types.svh.
REQ-036 One sub-module, llc_flush_walk_cnt (set/way counter with increment, clear, last-line flag), is natural; the rest stays flat.

Verification (bench: LLC_SETS=4, LLC_WAYS=2, MAX_OUTST=2)
REQ-037 start pulse, line_ready=1, line_done one cycle after each handshake -> 8 handshakes (0,0),(0,1),(1,0)...(3,1), then done_valid; done_ready -> IDLE.
REQ-038 line_ready=0 for 3 cycles on (1,1) -> line_set=1, line_way=1 held stable; no skipped or repeated line.
REQ-039 line_done withheld -> exactly 2 handshakes then line_valid=0; one line_done -> exactly one more issue.
REQ-040 pause=1 for 5 cycles mid-walk -> no handshakes; pending line_done still decrements outstanding; walk resumes where it stopped.
REQ-041 Handshake and line_done in the same cycle with outstanding=1 -> outstanding stays 1; line_done at outstanding=0 in IDLE -> err_underflow=1 and sticky.
REQ-042 rst low during set 2 -> all outputs at reset values same cycle; new start restarts at (0,0); second start_valid during DRAIN held until IDLE.
